// File: rtl/axi_lite_req_arbiter_if.sv
// AXI4-Lite master-side bundle used by axi_lite_req_arbiter; master drives requests, slave replies.
interface axi_lite_req_arbiter_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
);
   logic [AddrWidth-1:0]   awaddr;
   logic                   awvalid;
   logic                   awready;
   logic [DataWidth-1:0]   wdata;
   logic [DataWidth/8-1:0] wstrb;
   logic                   wvalid;
   logic                   wready;
   logic [1:0]             bresp;
   logic                   bvalid;
   logic                   bready;
   logic [AddrWidth-1:0]   araddr;
   logic                   arvalid;
   logic                   arready;
   logic [DataWidth-1:0]   rdata;
   logic [1:0]             rresp;
   logic                   rvalid;
   logic                   rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave among NumReq clients, one transaction at a time.
module axi_lite_req_arbiter #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned NumReq    = 3
) (
   input  logic                           aclk_i,
   input  logic                           aresetn_i,
   input  logic [NumReq-1:0]              req_valid_i,
   output logic [NumReq-1:0]              req_ready_o,
   input  logic [NumReq-1:0]              req_write_i,
   input  logic [NumReq*AddrWidth-1:0]    req_addr_i,
   input  logic [NumReq*DataWidth-1:0]    req_wdata_i,
   output logic [NumReq-1:0]              rsp_valid_o,
   output logic [DataWidth-1:0]           rsp_rdata_o,
   output logic [1:0]                     rsp_resp_o,
   axi_lite_req_arbiter_if.master         m_axi
);

   localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StWrAddrData,
      StWrResp,
      StRdAddr,
      StRdData
   } state_e;

   state_e                state_q, state_d;
   logic [IdxW-1:0]       last_q, last_d;
   logic [AddrWidth-1:0]  addr_q, addr_d;
   logic [DataWidth-1:0]  wdata_q, wdata_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic [NumReq-1:0]     rsp_valid_q, rsp_valid_d;
   logic [DataWidth-1:0]  rdata_q, rdata_d;
   logic [1:0]            resp_q, resp_d;

   logic                  grant_found;
   logic [IdxW-1:0]       grant_idx;

   // Rotating priority: the client just after the last grant is searched first.
   always_comb begin
      int unsigned c;
      c           = 0;
      grant_found = 1'b0;
      grant_idx   = last_q;
      for (int unsigned i = 1; i <= NumReq; i++) begin
         c = 32'(last_q) + i;
         if (c >= NumReq) c = c - NumReq;
         if (!grant_found && req_valid_i[c]) begin
            grant_found = 1'b1;
            grant_idx   = IdxW'(c);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rsp_valid_d = '0;
      rdata_d     = rdata_q;
      resp_d      = resp_q;
      req_ready_o = '0;

      unique case (state_q)
         StIdle: begin
            if (aresetn_i && grant_found) begin
               req_ready_o[grant_idx] = 1'b1;
               last_d    = grant_idx;
               addr_d    = req_addr_i[grant_idx*AddrWidth +: AddrWidth];
               wdata_d   = req_wdata_i[grant_idx*DataWidth +: DataWidth];
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = req_write_i[grant_idx] ? StWrAddrData : StRdAddr;
            end
         end
         StWrAddrData: begin
            if (m_axi.awvalid && m_axi.awready) aw_done_d = 1'b1;
            if (m_axi.wvalid && m_axi.wready)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d)          state_d   = StWrResp;
         end
         StWrResp: begin
            if (m_axi.bvalid) begin
               resp_d              = m_axi.bresp;
               rsp_valid_d[last_q] = 1'b1;
               state_d             = StIdle;
            end
         end
         StRdAddr: begin
            if (m_axi.arready) state_d = StRdData;
         end
         StRdData: begin
            if (m_axi.rvalid) begin
               rdata_d             = m_axi.rdata;
               resp_d              = m_axi.rresp;
               rsp_valid_d[last_q] = 1'b1;
               state_d             = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         state_q     <= StIdle;
         last_q      <= IdxW'(NumReq - 1);
         addr_q      <= '0;
         wdata_q     <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_valid_q <= '0;
         rdata_q     <= '0;
         resp_q      <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         resp_q      <= resp_d;
      end
   end

   // Valids decode from registered state, so they drop with reset and payloads stay frozen.
   assign m_axi.awaddr  = addr_q;
   assign m_axi.awvalid = (state_q == StWrAddrData) && !aw_done_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = '1;
   assign m_axi.wvalid  = (state_q == StWrAddrData) && !w_done_q;
   assign m_axi.bready  = (state_q == StWrResp);
   assign m_axi.araddr  = addr_q;
   assign m_axi.arvalid = (state_q == StRdAddr);
   assign m_axi.rready  = (state_q == StRdData);

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_resp_o  = resp_q;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Bench for axi_lite_req_arbiter: GPIO-like slave model, transaction-level reference model, directed tests.
module tb_axi_lite_req_arbiter;
   localparam int N = 3;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_write = '0;
   logic [N*32-1:0] req_addr  = '0;
   logic [N*32-1:0] req_wdata = '0;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [31:0]     rsp_rdata;
   logic [1:0]      rsp_resp;

   axi_lite_req_arbiter_if #(.AddrWidth(32), .DataWidth(32)) m_axi ();

   axi_lite_req_arbiter #(.AddrWidth(32), .DataWidth(32), .NumReq(N)) dut (
      .aclk_i      (aclk),
      .aresetn_i   (aresetn),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_write_i (req_write),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .rsp_resp_o  (rsp_resp),
      .m_axi       (m_axi)
   );

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Slave: ready after a configurable wait, B/R one cycle after the address/data handshakes.
   int          aw_delay = 1, w_delay = 1, ar_delay = 1, r_delay = 0;
   logic [1:0]  bresp_cfg = 2'b00;
   logic [31:0] gpio_out = '0;
   logic [31:0] gpio_in = 32'h1234_5678;
   logic [31:0] last_araddr = '0;

   initial begin
      logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, rd_pend;
      logic [31:0] c_awaddr, c_wdata, c_araddr, s_awaddr, s_wdata;
      int          aw_cnt, w_cnt, ar_cnt, r_cnt;
      got_aw = 0; got_w = 0; rd_pend = 0; s_awaddr = '0; s_wdata = '0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0; m_axi.bresp = 0;
      m_axi.arready = 0; m_axi.rvalid = 0; m_axi.rdata = 0; m_axi.rresp = 0;
      forever begin
         @(negedge aclk);
         aw_hs = m_axi.awvalid && m_axi.awready;
         w_hs  = m_axi.wvalid && m_axi.wready;
         b_hs  = m_axi.bvalid && m_axi.bready;
         ar_hs = m_axi.arvalid && m_axi.arready;
         r_hs  = m_axi.rvalid && m_axi.rready;
         c_awaddr = m_axi.awaddr; c_wdata = m_axi.wdata; c_araddr = m_axi.araddr;
         @(posedge aclk);
         #1;
         if (!aresetn) begin
            got_aw = 0; got_w = 0; rd_pend = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
            m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0;
            m_axi.arready = 0; m_axi.rvalid = 0;
            continue;
         end
         if (aw_hs) begin got_aw = 1; s_awaddr = c_awaddr; end
         if (w_hs)  begin got_w = 1;  s_wdata = c_wdata;   end
         if (b_hs)  m_axi.bvalid = 0;
         if (got_aw && got_w) begin
            if (s_awaddr == 32'h0) gpio_out = s_wdata;
            m_axi.bvalid = 1; m_axi.bresp = bresp_cfg;
            got_aw = 0; got_w = 0;
         end
         if (ar_hs) begin rd_pend = 1; r_cnt = 0; last_araddr = c_araddr; end
         if (r_hs) m_axi.rvalid = 0;
         if (rd_pend) begin
            if (r_cnt >= r_delay) begin
               m_axi.rvalid = 1; m_axi.rresp = 2'b00; rd_pend = 0;
               m_axi.rdata = (last_araddr == 32'h8) ? gpio_in :
                             (last_araddr == 32'h0) ? gpio_out : 32'hDEAD_BEEF;
            end else r_cnt++;
         end
         if (m_axi.awvalid && !got_aw) begin m_axi.awready = (aw_cnt >= aw_delay); aw_cnt++; end
         else begin m_axi.awready = 0; aw_cnt = 0; end
         if (m_axi.wvalid && !got_w) begin m_axi.wready = (w_cnt >= w_delay); w_cnt++; end
         else begin m_axi.wready = 0; w_cnt = 0; end
         if (m_axi.arvalid) begin m_axi.arready = (ar_cnt >= ar_delay); ar_cnt++; end
         else begin m_axi.arready = 0; ar_cnt = 0; end
      end
   end

   // Transaction-level reference: round-robin grant, then one transaction, then one response.
   bit          m_busy = 0, m_write = 0, m_rsp_pend = 0, spacing_chk = 0;
   int          m_client = 0, m_last = N - 1, m_age = 0, m_aw = 0, m_w = 0, m_ar = 0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_exp_rdata = '0;
   logic [1:0]  m_exp_resp = '0;
   int          cyc = 0, prev_gcyc = -100;
   int          grant_log[$];
   int          rsp_count = 0, last_rsp_client = -1;
   logic [1:0]  last_rsp_resp = '0;
   logic [31:0] last_rsp_rdata = '0;

   initial begin
      logic [N-1:0] exp_rsp, exp_ready;
      bit           granted;
      int           c;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_rsp_resp", rsp_resp, 0);
            check("rst_axi_valids", {m_axi.awvalid, m_axi.wvalid, m_axi.arvalid,
                                     m_axi.bready, m_axi.rready}, 0);
            check("rst_axi_payload", {m_axi.awaddr, m_axi.araddr}, 0);
            m_busy = 0; m_rsp_pend = 0; m_last = N - 1; m_exp_rdata = '0; m_exp_resp = '0;
            prev_gcyc = -100;
            continue;
         end
         exp_rsp = m_rsp_pend ? N'(1 << m_client) : '0;
         check("rsp_valid", rsp_valid, exp_rsp);
         check("rsp_rdata", rsp_rdata, m_exp_rdata);
         check("rsp_resp", rsp_resp, m_exp_resp);
         if (m_rsp_pend) begin
            if (m_write) check("wr_hs_counts", {m_aw[7:0], m_w[7:0]}, 16'h0101);
            else         check("rd_hs_count", m_ar, 1);
            rsp_count++;
            last_rsp_client = m_client;
            last_rsp_resp   = m_exp_resp;
            last_rsp_rdata  = m_exp_rdata;
            m_busy = 0; m_rsp_pend = 0;
         end
         exp_ready = '0;
         granted   = 0;
         if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
               c = (m_last + k) % N;
               if (!granted && req_valid[c]) begin
                  granted = 1; exp_ready[c] = 1'b1;
                  m_busy = 1; m_client = c; m_last = c; m_write = req_write[c];
                  m_addr = req_addr[c*32 +: 32]; m_wdata = req_wdata[c*32 +: 32];
                  m_age = 0; m_aw = 0; m_w = 0; m_ar = 0;
                  grant_log.push_back(c);
                  if (spacing_chk && prev_gcyc >= 0) check("grant_spacing", (cyc - prev_gcyc) <= 6, 1);
                  prev_gcyc = cyc;
               end
            end
         end
         check("req_ready", req_ready, exp_ready);
         if (m_busy && !granted) begin
            m_age++;
            if (m_write) begin
               check("wr_no_ar", m_axi.arvalid, 0);
               if (m_age == 1) check("aw_w_first", {m_axi.awvalid, m_axi.wvalid}, 2'b11);
               if (m_axi.awvalid) check("awaddr", m_axi.awaddr, m_addr);
               if (m_axi.wvalid) begin
                  check("wdata", m_axi.wdata, m_wdata);
                  check("wstrb", m_axi.wstrb, 4'hF);
               end
               if (m_axi.bready) check("bready_after_aw_w", (m_aw == 1) && (m_w == 1), 1);
               if (m_axi.awvalid && m_axi.awready) m_aw++;
               if (m_axi.wvalid && m_axi.wready) m_w++;
               if (m_axi.bready && m_axi.bvalid) begin m_rsp_pend = 1; m_exp_resp = m_axi.bresp; end
            end else begin
               check("rd_no_aw_w", {m_axi.awvalid, m_axi.wvalid}, 0);
               if (m_age == 1) check("ar_first", m_axi.arvalid, 1);
               if (m_axi.arvalid) check("araddr", m_axi.araddr, m_addr);
               if (m_axi.rready) check("rready_after_ar", m_ar, 1);
               if (m_axi.arvalid && m_axi.arready) m_ar++;
               if (m_axi.rready && m_axi.rvalid) begin
                  m_rsp_pend = 1; m_exp_resp = m_axi.rresp; m_exp_rdata = m_axi.rdata;
               end
            end
         end
         cyc++;
      end
   end

   logic        cli_write[N];
   logic [31:0] cli_addr[N];
   logic [31:0] cli_data[N];

   task automatic set_cli(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
      cli_write[i] = w; cli_addr[i] = a; cli_data[i] = d;
   endtask

   task automatic issue(input logic [N-1:0] mask);
      logic [N-1:0] pend, got;
      int           budget;
      pend = mask;
      for (int i = 0; i < N; i++) begin
         if (mask[i]) begin
            req_valid[i] = 1'b1; req_write[i] = cli_write[i];
            req_addr[i*32 +: 32] = cli_addr[i]; req_wdata[i*32 +: 32] = cli_data[i];
         end
      end
      budget = 0;
      while (pend != 0 && budget < 200) begin
         @(negedge aclk);
         got = req_ready & pend;
         @(posedge aclk);
         #1;
         req_valid = req_valid & ~got;
         pend = pend & ~got;
         budget++;
      end
      check("issue_timeout", pend, 0);
   endtask

   task automatic wait_idle();
      int budget;
      budget = 0;
      while ((m_busy || m_rsp_pend) && budget < 200) begin
         @(posedge aclk);
         #1;
         budget++;
      end
      check("idle_timeout", m_busy, 0);
   endtask

   initial begin
      int exp_rr[6];
      int saved;
      exp_rr = '{0, 1, 2, 0, 1, 2};
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      #1;

      // Client 0 writes 0xA5 to the GPIO output register.
      set_cli(0, 1'b1, 32'h0, 32'h0000_00A5);
      issue(3'b001);
      wait_idle();
      check("t1_client", last_rsp_client, 0);
      check("t1_resp", last_rsp_resp, 2'b00);
      check("t1_gpio_out", gpio_out, 32'h0000_00A5);

      // Client 2 reads the GPIO input register.
      set_cli(2, 1'b0, 32'h8, 32'h0);
      issue(3'b100);
      wait_idle();
      check("t2_araddr", last_araddr, 32'h8);
      check("t2_client", last_rsp_client, 2);
      check("t2_rdata", last_rsp_rdata, 32'h1234_5678);
      check("t2_resp", last_rsp_resp, 2'b00);

      // All three clients request continuously.
      grant_log.delete();
      spacing_chk = 1;
      set_cli(0, 1'b1, 32'h0, 32'h11);
      set_cli(1, 1'b0, 32'h8, 32'h0);
      set_cli(2, 1'b1, 32'h4, 32'h22);
      issue(3'b111);
      issue(3'b111);
      wait_idle();
      spacing_chk = 0;
      check("t3_log_size", grant_log.size(), 6);
      for (int i = 0; i < 6 && i < grant_log.size(); i++) check("t3_rr_order", grant_log[i], exp_rr[i]);

      // After client 1 alone, a 0+1 request goes to client 0 first.
      grant_log.delete();
      issue(3'b010);
      issue(3'b011);
      wait_idle();
      check("t3b_log_size", grant_log.size(), 3);
      if (grant_log.size() == 3) begin
         check("t3b_first", grant_log[0], 1);
         check("t3b_second", grant_log[1], 0);
         check("t3b_third", grant_log[2], 1);
      end

      // Skewed AW/W acceptance in both directions.
      aw_delay = 1; w_delay = 4;
      set_cli(0, 1'b1, 32'h0, 32'h5A);
      issue(3'b001);
      wait_idle();
      check("t4a_gpio_out", gpio_out, 32'h5A);
      aw_delay = 4; w_delay = 1;
      set_cli(1, 1'b1, 32'h0, 32'h3C);
      issue(3'b010);
      wait_idle();
      check("t4b_gpio_out", gpio_out, 32'h3C);
      check("t4b_client", last_rsp_client, 1);
      aw_delay = 1; w_delay = 1;

      // SLVERR passes through, then a normal read follows.
      bresp_cfg = 2'b10;
      set_cli(1, 1'b1, 32'h4, 32'h77);
      issue(3'b010);
      wait_idle();
      check("t5_client", last_rsp_client, 1);
      check("t5_resp", last_rsp_resp, 2'b10);
      bresp_cfg = 2'b00;
      set_cli(1, 1'b0, 32'h8, 32'h0);
      issue(3'b010);
      wait_idle();
      check("t5b_resp", last_rsp_resp, 2'b00);
      check("t5b_rdata", last_rsp_rdata, 32'h1234_5678);

      // Reset while waiting for R: everything clears at once, no response.
      r_delay = 6;
      saved = rsp_count;
      set_cli(1, 1'b0, 32'h8, 32'h0);
      issue(3'b010);
      for (int i = 0; i < 50 && !m_axi.rready; i++) @(negedge aclk);
      check("t6_rready_seen", m_axi.rready, 1);
      #2 aresetn = 1'b0;
      #1;
      check("t6_async_valids", {m_axi.rready, m_axi.arvalid, m_axi.awvalid, m_axi.wvalid}, 0);
      check("t6_async_rdata", rsp_rdata, 0);
      check("t6_async_araddr", m_axi.araddr, 0);
      check("t6_async_rsp_valid", rsp_valid, 0);
      r_delay = 0;
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
      repeat (4) @(posedge aclk);
      #1;
      check("t6_no_rsp", rsp_count, saved);
      grant_log.delete();
      set_cli(0, 1'b0, 32'h8, 32'h0);
      issue(3'b011);
      wait_idle();
      check("t6_log_size", grant_log.size(), 2);
      if (grant_log.size() == 2) check("t6_first_after_reset", grant_log[0], 0);

      repeat (3) @(posedge aclk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got %0d compared, expected completion",
               n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
